// File: rtl/contador_progresivo.sv
// Programmable up-counter: counts 0..limit_q, then stops (done) or wraps to 0 (wrap pulse).
// Latency: start accepted at edge k gives count=0 after edge k and count=i after edge k+i.
// Backpressure: none; pause holds the count, and start is ignored while RUN or PAUSE.
//
// Ports:
//   clk       rising-edge clock
//   rst_async asynchronous active-low reset
//   start     start request (accepted in IDLE and DONE)
//   pause     level; holds the count while high
//   clear     synchronous return to IDLE, count cleared
//   wrap_en   1 = wrap at limit, 0 = stop at limit (read every cycle)
//   limit     terminal count, sampled only when a start is accepted
//   count     current count (registered)
//   busy      high in RUN or PAUSE
//   done      high in DONE
//   wrap      one-cycle pulse following each wrap to 0
module contador_progresivo #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_async,
  input  logic         start,
  input  logic         pause,
  input  logic         clear,
  input  logic         wrap_en,
  input  logic [N-1:0] limit,
  output logic [N-1:0] count,
  output logic         busy,
  output logic         done,
  output logic         wrap
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t       state;
  logic [N-1:0] limit_q;
  logic [N-1:0] count_inc;
  // carry[i] is the carry out of cell i into cell i+1. The top cell's carry-out
  // is never needed: the count is never incremented past limit_q, so it is not built.
  logic [N-2:0] carry;

  // Ripple-carry incrementer: one 1-bit full-adder cell per bit. Cell 0 adds the
  // constant 1 with no carry-in; every higher cell adds 0 plus the carry below it.
  for (genvar i = 0; i < N; i++) begin : g_inc
    logic a;
    logic b;
    logic cin;

    assign a = count[i];
    assign b = (i == 0) ? 1'b1 : 1'b0;

    if (i == 0) begin : g_cin0
      assign cin = 1'b0;
    end else begin : g_cinn
      assign cin = carry[i-1];
    end

    assign count_inc[i] = a ^ b ^ cin;

    if (i < N - 1) begin : g_cout
      assign carry[i] = (a & b) | (cin & (a ^ b));
    end
  end

  always_ff @(posedge clk or negedge rst_async) begin
    if (!rst_async) begin
      state   <= IDLE;
      count   <= '0;
      limit_q <= '0;
      wrap    <= 1'b0;
    end else begin
      // wrap is a single-cycle pulse; only the wrap branch below raises it.
      wrap <= 1'b0;
      if (clear) begin
        state <= IDLE;
        count <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state   <= RUN;
              count   <= '0;
              limit_q <= limit;
            end
          end
          RUN: begin
            // start is deliberately not looked at here: a running count is never restarted.
            if (pause) begin
              state <= PAUSE;
            end else if (count != limit_q) begin
              count <= count_inc;
            end else if (!wrap_en) begin
              state <= DONE;
            end else begin
              count <= '0;
              wrap  <= 1'b1;
            end
          end
          PAUSE: begin
            // Leaving PAUSE costs one edge with the count unchanged.
            if (!pause) begin
              state <= RUN;
            end
          end
          DONE: begin
            if (start) begin
              state   <= RUN;
              count   <= '0;
              limit_q <= limit;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Status flags decode the state register directly, so they follow the async reset.
  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_contador_progresivo.sv
module tb_contador_progresivo;

  logic       clk;
  logic       rst_async;
  logic       start;
  logic       pause;
  logic       clear;
  logic       wrap_en;
  logic [7:0] limit;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       wrap;

  int n_total;
  int n_pass;

  contador_progresivo #(.N(8)) dut (
    .clk      (clk),
    .rst_async(rst_async),
    .start    (start),
    .pause    (pause),
    .clear    (clear),
    .wrap_en  (wrap_en),
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .wrap     (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       s;
    logic       p;
    logic       c;
    logic       we;
    logic [7:0] lim;
    logic [7:0] ec;
    logic       eb;
    logic       ed;
    logic       ew;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic       b;
    logic       d;
    logic       w;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic s, p, c, we, input logic [7:0] lim,
                              input logic [7:0] ec, input logic eb, ed, ew);
    vec_t v;
    v.s = s; v.p = p; v.c = c; v.we = we; v.lim = lim;
    v.ec = ec; v.eb = eb; v.ed = ed; v.ew = ew;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_total++;
    if (act != exp) begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Drive one cycle of inputs, push the expectation, and compare it once the DUT has clocked.
  task automatic cyc(input logic s, p, c, we, input logic [7:0] lim,
                     input logic [7:0] ec, input logic eb, ed, ew, input string tag);
    exp_t e;
    start = s; pause = p; clear = c; wrap_en = we; limit = lim;
    e.cnt = ec; e.b = eb; e.d = ed; e.w = ew;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, ".count"}, int'(count), int'(e.cnt));
      chk({tag, ".busy"},  int'(busy),  int'(e.b));
      chk({tag, ".done"},  int'(done),  int'(e.d));
      chk({tag, ".wrap"},  int'(wrap),  int'(e.w));
    end
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    rst_async = 1'b0;
    start = 0; pause = 0; clear = 0; wrap_en = 0; limit = 8'd0;

    // Vector table: {start,pause,clear,wrap_en,limit} -> {count,busy,done,wrap}, from IDLE.
    vecs.push_back(mk(1,0,0,1, 8'd3,  8'd0, 1,0,0)); // wrap mode, limit 3
    vecs.push_back(mk(0,0,0,1, 8'd3,  8'd1, 1,0,0));
    vecs.push_back(mk(0,0,0,1, 8'd3,  8'd2, 1,0,0));
    vecs.push_back(mk(0,0,0,1, 8'd3,  8'd3, 1,0,0));
    vecs.push_back(mk(0,0,0,1, 8'd3,  8'd0, 1,0,1)); // wrap pulse
    vecs.push_back(mk(0,0,0,1, 8'd3,  8'd1, 1,0,0));
    vecs.push_back(mk(1,0,0,1, 8'd9,  8'd2, 1,0,0)); // start in RUN ignored
    vecs.push_back(mk(0,0,0,1, 8'd9,  8'd3, 1,0,0)); // limit change has no effect
    vecs.push_back(mk(0,0,0,1, 8'd9,  8'd0, 1,0,1));
    vecs.push_back(mk(0,0,1,1, 8'd9,  8'd0, 0,0,0)); // clear
    vecs.push_back(mk(1,0,0,1, 8'd0,  8'd0, 1,0,0)); // limit 0, wrap mode
    vecs.push_back(mk(0,0,0,1, 8'd0,  8'd0, 1,0,1));
    vecs.push_back(mk(0,0,0,1, 8'd0,  8'd0, 1,0,1));
    vecs.push_back(mk(0,0,0,0, 8'd0,  8'd0, 0,1,0)); // wrap_en read live -> DONE
    vecs.push_back(mk(0,0,0,0, 8'd0,  8'd0, 0,1,0));
    vecs.push_back(mk(0,0,0,0, 8'd50, 8'd0, 0,1,0)); // limit change in DONE ignored
    vecs.push_back(mk(1,0,0,0, 8'd2,  8'd0, 1,0,0)); // restart from DONE, new limit
    vecs.push_back(mk(0,0,0,0, 8'd2,  8'd1, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 8'd0,  8'd2, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 8'd0,  8'd2, 0,1,0));
    vecs.push_back(mk(1,0,1,0, 8'd4,  8'd0, 0,0,0)); // clear beats start
    vecs.push_back(mk(0,0,0,0, 8'd4,  8'd0, 0,0,0));
    vecs.push_back(mk(1,0,0,0, 8'd5,  8'd0, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 8'd5,  8'd1, 1,0,0));
    vecs.push_back(mk(0,1,0,0, 8'd5,  8'd1, 1,0,0)); // enter PAUSE
    vecs.push_back(mk(1,1,0,0, 8'd5,  8'd1, 1,0,0)); // start in PAUSE ignored
    vecs.push_back(mk(0,0,0,0, 8'd5,  8'd1, 1,0,0)); // back to RUN, count unchanged
    vecs.push_back(mk(0,0,0,0, 8'd5,  8'd2, 1,0,0));
    vecs.push_back(mk(0,1,0,0, 8'd5,  8'd2, 1,0,0));
    vecs.push_back(mk(0,1,1,0, 8'd5,  8'd0, 0,0,0)); // clear from PAUSE

    // Reset state, checked with no clock edge yet.
    #2;
    chk("reset.count", int'(count), 0);
    chk("reset.busy",  int'(busy),  0);
    chk("reset.done",  int'(done),  0);
    chk("reset.wrap",  int'(wrap),  0);
    #1 rst_async = 1'b1;

    cyc(0,0,0,0, 8'd7, 8'd0, 0,0,0, "idle0");
    cyc(0,0,0,0, 8'd7, 8'd0, 0,0,0, "idle1");

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].s, vecs[i].p, vecs[i].c, vecs[i].we, vecs[i].lim,
          vecs[i].ec, vecs[i].eb, vecs[i].ed, vecs[i].ew, $sformatf("vec%0d", i));
    end

    // Stop mode, limit 10.
    cyc(1,0,0,0, 8'd10, 8'd0, 1,0,0, "stop10.start");
    for (int i = 1; i <= 10; i++)
      cyc(0,0,0,0, 8'd10, 8'(i), 1,0,0, $sformatf("stop10.c%0d", i));
    cyc(0,0,0,0, 8'd10, 8'd10, 0,1,0, "stop10.done");
    cyc(0,0,0,0, 8'd10, 8'd10, 0,1,0, "stop10.hold");
    cyc(0,0,1,0, 8'd10, 8'd0, 0,0,0, "stop10.clear");

    // Full-range limit: reaches 255 and stops without rolling over.
    cyc(1,0,0,0, 8'd255, 8'd0, 1,0,0, "lim255.start");
    for (int i = 1; i <= 255; i++)
      cyc(0,0,0,0, 8'd3, 8'(i), 1,0,0, $sformatf("lim255.c%0d", i));
    cyc(0,0,0,0, 8'd3, 8'd255, 0,1,0, "lim255.done");
    cyc(0,0,0,0, 8'd3, 8'd255, 0,1,0, "lim255.hold");
    cyc(0,0,1,0, 8'd3, 8'd0, 0,0,0, "lim255.clear");

    // Pause held for 4 edges at count 2 with limit 6: done arrives 5 cycles late.
    cyc(1,0,0,0, 8'd6, 8'd0, 1,0,0, "pause.start");
    cyc(0,0,0,0, 8'd6, 8'd1, 1,0,0, "pause.c1");
    cyc(0,0,0,0, 8'd6, 8'd2, 1,0,0, "pause.c2");
    for (int i = 0; i < 4; i++)
      cyc(0,1,0,0, 8'd6, 8'd2, 1,0,0, $sformatf("pause.hold%0d", i));
    cyc(0,0,0,0, 8'd6, 8'd2, 1,0,0, "pause.resume");
    for (int i = 3; i <= 6; i++)
      cyc(0,0,0,0, 8'd6, 8'(i), 1,0,0, $sformatf("pause.c%0d", i));
    cyc(0,0,0,0, 8'd6, 8'd6, 0,1,0, "pause.done");

    // Asynchronous reset in the middle of a run at count 5.
    cyc(1,0,0,0, 8'd20, 8'd0, 1,0,0, "arst.start");
    for (int i = 1; i <= 5; i++)
      cyc(0,0,0,0, 8'd20, 8'(i), 1,0,0, $sformatf("arst.c%0d", i));
    rst_async = 1'b0;
    #2;
    chk("arst.count", int'(count), 0);
    chk("arst.busy",  int'(busy),  0);
    chk("arst.done",  int'(done),  0);
    chk("arst.wrap",  int'(wrap),  0);
    #1 rst_async = 1'b1;
    cyc(0,0,0,0, 8'd20, 8'd0, 0,0,0, "arst.idle0");
    cyc(0,0,0,0, 8'd20, 8'd0, 0,0,0, "arst.idle1");
    cyc(1,0,0,0, 8'd2,  8'd0, 1,0,0, "arst.restart");
    cyc(0,0,0,0, 8'd2,  8'd1, 1,0,0, "arst.r1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
